// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM states and constants for the PWM duty decoder
package pwm_pkg;
  typedef enum logic [1:0] {WAIT_EDGE, MEASURE, DIVIDE} state_t;
  localparam int DUTY_W = 7;
  localparam int PCT_SCALE = 100;
  localparam int DIV_STEPS = 7;
endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: serial restoring divider, one quotient bit per cycle, first bit resolved on the start edge
module pwm_duty_div
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CNT_W+DUTY_W-1:0]   num,
  input  logic [CNT_W-1:0]          den,
  output logic                      busy,
  output logic                      done,
  output logic [DUTY_W-1:0]         quo
);
  localparam int NW = CNT_W + DUTY_W;
  localparam int IW = $clog2(DIV_STEPS);
  logic [NW-1:0] rem, rem_in, sub;
  logic [CNT_W-1:0] dvs, den_in;
  logic [IW-1:0] idx, idx_in;
  logic [DUTY_W-1:0] q_in;
  logic ge;
  // start injects fresh operands so the MSB step happens on the start edge itself
  always_comb begin
    rem_in = start ? num : rem;
    den_in = start ? den : dvs;
    idx_in = start ? IW'(DIV_STEPS - 1) : idx;
    q_in = start ? '0 : quo;
    sub = NW'(den_in) << idx_in;
    ge = rem_in >= sub;
  end
  // iterate while busy; done pulses the cycle after the last quotient bit lands
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rem <= '0;
      dvs <= '0;
      idx <= '0;
      quo <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start || busy) begin
        rem <= ge ? rem_in - sub : rem_in;
        dvs <= den_in;
        quo <= {q_in[DUTY_W-2:0], ge};
        idx <= idx_in - 1'b1;
        busy <= idx_in != '0;
        done <= idx_in == '0;
      end
    end
endmodule

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures period, high time and duty percent of an async PWM input; PWM_DECODE_FILTER_EN adds a glitch filter
module pwm_duty_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int unsigned TIMEOUT = 'hFFFF
`ifdef PWM_DECODE_FILTER_EN
  , parameter int FILT_LEN = 3
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty_pct,
  output logic [CNT_W-1:0]  period,
  output logic [CNT_W-1:0]  high_time,
  output logic              valid,
  output logic              stalled,
  output logic              overrun
);
  localparam int NW = CNT_W + DUTY_W;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);
  state_t state, state_nx;
  logic [1:0] sync;
  logic lvl, lvl_d, rise, tmo, start, div_busy, div_done;
  logic [CNT_W-1:0] period_cnt, high_cnt, cap_period, cap_high;
  logic [NW-1:0] num;
  logic [DUTY_W-1:0] quo;
  // two-flop synchronizer and the one-cycle-delayed level for edge detection
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= '0;
      lvl_d <= 1'b0;
    end else begin
      sync <= {sync[0], pwm_in};
      lvl_d <= lvl;
    end
`ifdef PWM_DECODE_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);
  logic [FW-1:0] fcnt;
  // level follows the synchronizer only after FILT_LEN consecutive disagreeing samples
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      fcnt <= '0;
      lvl <= 1'b0;
    end else if (sync[1] == lvl) fcnt <= '0;
    else if (fcnt == FW'(FILT_LEN - 1)) begin
      lvl <= sync[1];
      fcnt <= '0;
    end else fcnt <= fcnt + 1'b1;
`else
  assign lvl = sync[1];
`endif
  assign rise = lvl & ~lvl_d;
  assign num = NW'(high_cnt) * NW'(PCT_SCALE);
  // both counters restart on a rise and park at TIMEOUT on a static input
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      period_cnt <= '0;
      high_cnt <= '0;
    end else begin
      period_cnt <= rise ? CNT_W'(1) : period_cnt == TMO ? period_cnt : period_cnt + 1'b1;
      high_cnt <= rise ? CNT_W'(1) : (lvl && high_cnt != TMO) ? high_cnt + 1'b1 : high_cnt;
    end
  // captures only from MEASURE; a static input times out once from WAIT_EDGE or MEASURE
  always_comb begin
    tmo = state != DIVIDE && !rise && !stalled && period_cnt == TMO;
    start = state == MEASURE && rise;
    state_nx = tmo ? WAIT_EDGE :
               state == WAIT_EDGE ? (rise ? MEASURE : WAIT_EDGE) :
               state == MEASURE ? (rise ? DIVIDE : MEASURE) :
               (div_done ? MEASURE : DIVIDE);
  end
  // state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= WAIT_EDGE;
    else state <= state_nx;
  // snapshot of the finished period, held for the report
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cap_period <= '0;
      cap_high <= '0;
    end else if (start) begin
      cap_period <= period_cnt;
      cap_high <= high_cnt;
    end
  pwm_duty_div #(.CNT_W(CNT_W)) u_div (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .num   (num),
    .den   (period_cnt),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (quo)
  );
  // reported values, valid strobe, stall flag and sticky overrun
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      duty_pct <= '0;
      period <= '0;
      high_time <= '0;
      valid <= 1'b0;
      stalled <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid <= div_done | tmo;
      if (div_done) begin
        period <= cap_period;
        high_time <= cap_high;
        duty_pct <= quo;
      end else if (tmo) begin
        period <= '0;
        high_time <= '0;
        duty_pct <= lvl ? DUTY_W'(PCT_SCALE) : '0;
      end
      stalled <= tmo ? 1'b1 : rise ? 1'b0 : stalled;
      overrun <= overrun | (rise & (div_busy | div_done));
    end
endmodule
